// File: rtl/mem_access.sv
// mem_access: memory pipeline stage with a req/ack data-memory handshake and a timeout.
// Ports: execute-side inputs, dmem_* request/response, writeback outputs, stall_in/flush_in/stall_out.
module mem_access #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int EX_W    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pipeline_in_valid,
  input  logic [4:0]         opcode_in,
  input  logic [2:0]         funct_in,
  input  logic               nop_instr_in,
  input  logic [EX_W-1:0]    exception_in,
  input  logic               exception_in_valid,
  input  logic [DATA_W-1:0]  result_in,
  input  logic [ADDR_W-1:0]  addr_in,
  input  logic [RADDR_W-1:0] rd_addr_in,
  input  logic               stall_in,
  input  logic               flush_in,
  output logic               stall_out,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [ADDR_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  output logic [3:0]         dmem_be,
  input  logic               dmem_ack,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               pipeline_out_valid,
  output logic               wb_en,
  output logic [DATA_W-1:0]  wb_data,
  output logic [RADDR_W-1:0] rd_addr_out,
  output logic [EX_W-1:0]    exception_out,
  output logic               exception_out_valid
);

  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;
  localparam logic [4:0] OP_IMM   = 5'b00100;
  localparam logic [4:0] OP_AUIPC = 5'b00101;
  localparam logic [4:0] OP_ARITH = 5'b01100;
  localparam logic [4:0] OP_LUI   = 5'b01101;
  localparam logic [4:0] OP_JALR  = 5'b11001;
  localparam logic [4:0] OP_JAL   = 5'b11011;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [EX_W-1:0] EX_LD_MIS = EX_W'(4);
  localparam logic [EX_W-1:0] EX_LD_FLT = EX_W'(5);
  localparam logic [EX_W-1:0] EX_ST_MIS = EX_W'(6);
  localparam logic [EX_W-1:0] EX_ST_FLT = EX_W'(7);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_DRAIN} state_t;
  typedef enum logic [2:0] {O_HOLD, O_CLR, O_PT, O_RES, O_BUF} osel_t;

  state_t r_state, w_next;
  osel_t  w_osel;

  logic               r_req, r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [3:0]         r_be;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ld;
  logic [2:0]         r_f;
  logic [ADDR_W-1:0]  r_a;
  logic [RADDR_W-1:0] r_rd;

  logic               r_ov, r_wben, r_excv;
  logic [DATA_W-1:0]  r_wbd;
  logic [RADDR_W-1:0] r_rdo;
  logic [EX_W-1:0]    r_exc;

  logic               r_bwben, r_bexcv;
  logic [DATA_W-1:0]  r_bd;
  logic [EX_W-1:0]    r_bexc;

  logic w_is_load, w_is_store, w_mem_op, w_mis, w_mis_op, w_start;
  logic w_wb_op, w_timeout, w_done;
  logic w_acc_start, w_acc_end, w_buf_ld;
  logic [ADDR_W-1:0] w_a;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [15:0]       w_sh;
  logic [DATA_W-1:0] w_ld;

  logic               w_pt_wben, w_pt_excv;
  logic [EX_W-1:0]    w_pt_exc;
  logic [DATA_W-1:0]  w_pt_data;
  logic               w_res_wben, w_res_excv;
  logic [EX_W-1:0]    w_res_exc;
  logic [DATA_W-1:0]  w_res_data;

  always_comb begin
    w_is_load  = opcode_in == OP_LOAD;
    w_is_store = opcode_in == OP_STORE;
    w_mem_op   = pipeline_in_valid & ~nop_instr_in
               & ~exception_in_valid
               & (w_is_load | w_is_store);
    w_a = w_is_load ? ADDR_W'(result_in) : addr_in;
    w_mis = funct_in[1] ? (w_a[1:0] != 2'b00)
                        : (funct_in[0] & w_a[0]);
    w_mis_op = w_mem_op & w_mis;
    w_start  = w_mem_op & ~w_mis;
    w_wb_op  = opcode_in inside {OP_ARITH, OP_IMM, OP_LUI,
                                 OP_AUIPC, OP_JAL, OP_JALR,
                                 OP_LOAD};
    if (funct_in[1]) begin
      w_be    = 4'b1111;
      w_wdata = result_in;
    end else if (funct_in[0]) begin
      w_be    = 4'b0011 << w_a[1:0];
      w_wdata = {(DATA_W/16){result_in[15:0]}};
    end else begin
      w_be    = 4'b0001 << w_a[1:0];
      w_wdata = {(DATA_W/8){result_in[7:0]}};
    end
  end

  // Pass-through result, including the misaligned-access fault.
  always_comb begin
    w_pt_excv = pipeline_in_valid
              & ((~nop_instr_in & exception_in_valid) | w_mis_op);
    if (w_mis_op)
      w_pt_exc = w_is_load ? EX_LD_MIS : EX_ST_MIS;
    else
      w_pt_exc = w_pt_excv ? exception_in : '0;
    w_pt_wben = pipeline_in_valid & ~nop_instr_in
              & ~exception_in_valid & ~w_mis_op & w_wb_op
              & (rd_addr_in != '0);
    w_pt_data = w_mis_op ? DATA_W'(w_a) : result_in;
  end

  // Completed access result (ack data or timeout fault).
  always_comb begin
    w_sh = 16'(dmem_rdata >> {r_a[1:0], 3'b000});
    if (r_f[1])
      w_ld = dmem_rdata;
    else if (r_f[0])
      w_ld = {{(DATA_W-16){w_sh[15] & ~r_f[2]}}, w_sh};
    else
      w_ld = {{(DATA_W-8){w_sh[7] & ~r_f[2]}}, w_sh[7:0]};
    w_timeout  = ~dmem_ack & (r_cnt == CNT_LAST);
    w_done     = dmem_ack | w_timeout;
    w_res_data = dmem_ack ? (r_ld ? w_ld : '0) : DATA_W'(r_a);
    w_res_excv = ~dmem_ack;
    w_res_exc  = dmem_ack ? '0 : (r_ld ? EX_LD_FLT : EX_ST_FLT);
    w_res_wben = dmem_ack & r_ld & (r_rd != '0);
  end

  always_comb begin
    w_next      = r_state;
    w_osel      = O_HOLD;
    w_acc_start = 1'b0;
    w_acc_end   = 1'b0;
    w_buf_ld    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (flush_in) begin
          w_osel = O_CLR;
        end else if (!stall_in) begin
          if (w_start) begin
            w_next      = S_WAIT;
            w_osel      = O_CLR;
            w_acc_start = 1'b1;
          end else begin
            w_osel = O_PT;
          end
        end
      end
      S_WAIT: begin
        w_acc_end = w_done;
        if (flush_in) begin
          w_next = w_done ? S_IDLE : S_DRAIN;
        end else if (w_done) begin
          if (stall_in) begin
            w_next   = S_RESP;
            w_buf_ld = 1'b1;
          end else begin
            w_next = S_IDLE;
            w_osel = O_RES;
          end
        end
      end
      S_RESP: begin
        if (flush_in) begin
          w_next = S_IDLE;
        end else if (!stall_in) begin
          w_next = S_IDLE;
          w_osel = O_BUF;
        end
      end
      S_DRAIN: begin
        if (w_done) begin
          w_next    = S_IDLE;
          w_acc_end = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_cnt   <= '0;
      r_ld    <= 1'b0;
      r_f     <= '0;
      r_a     <= '0;
      r_rd    <= '0;
      r_ov    <= 1'b0;
      r_wben  <= 1'b0;
      r_excv  <= 1'b0;
      r_wbd   <= '0;
      r_rdo   <= '0;
      r_exc   <= '0;
      r_bwben <= 1'b0;
      r_bexcv <= 1'b0;
      r_bd    <= '0;
      r_bexc  <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc_start) begin
        r_req   <= 1'b1;
        r_we    <= w_is_store;
        r_addr  <= {w_a[ADDR_W-1:2], 2'b00};
        r_be    <= w_be;
        r_wdata <= w_wdata;
        r_cnt   <= '0;
        r_ld    <= w_is_load;
        r_f     <= funct_in;
        r_a     <= w_a;
        r_rd    <= rd_addr_in;
      end else if (w_acc_end) begin
        r_req <= 1'b0;
        r_we  <= 1'b0;
      end else if (r_req) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_buf_ld) begin
        r_bwben <= w_res_wben;
        r_bexcv <= w_res_excv;
        r_bexc  <= w_res_exc;
        r_bd    <= w_res_data;
      end
      unique case (w_osel)
        O_CLR: begin
          r_ov   <= 1'b0;
          r_wben <= 1'b0;
          r_excv <= 1'b0;
          r_exc  <= '0;
        end
        O_PT: begin
          r_ov   <= pipeline_in_valid;
          r_wben <= w_pt_wben;
          r_excv <= w_pt_excv;
          r_exc  <= w_pt_exc;
          r_wbd  <= w_pt_data;
          r_rdo  <= rd_addr_in;
        end
        O_RES: begin
          r_ov   <= 1'b1;
          r_wben <= w_res_wben;
          r_excv <= w_res_excv;
          r_exc  <= w_res_exc;
          r_wbd  <= w_res_data;
          r_rdo  <= r_rd;
        end
        O_BUF: begin
          r_ov   <= 1'b1;
          r_wben <= r_bwben;
          r_excv <= r_bexcv;
          r_exc  <= r_bexc;
          r_wbd  <= r_bd;
          r_rdo  <= r_rd;
        end
        default: ;
      endcase
    end
  end

  assign stall_out = (r_state == S_IDLE && w_start)
                   | (r_state == S_WAIT && !w_done)
                   | (r_state == S_RESP)
                   | (r_state == S_DRAIN);

  assign dmem_req            = r_req;
  assign dmem_we             = r_we;
  assign dmem_addr           = r_addr;
  assign dmem_wdata          = r_wdata;
  assign dmem_be             = r_be;
  assign pipeline_out_valid  = r_ov;
  assign wb_en               = r_wben;
  assign wb_data             = r_wbd;
  assign rd_addr_out         = r_rdo;
  assign exception_out       = r_exc;
  assign exception_out_valid = r_excv;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized and directed checks of mem_access
// against a transaction-level model of the memory stage.
module tb_mem_access;

  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;
  localparam logic [4:0] OP_IMM   = 5'b00100;
  localparam logic [4:0] OP_AUIPC = 5'b00101;
  localparam logic [4:0] OP_ARITH = 5'b01100;
  localparam logic [4:0] OP_LUI   = 5'b01101;
  localparam logic [4:0] OP_JALR  = 5'b11001;
  localparam logic [4:0] OP_JAL   = 5'b11011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        pipeline_in_valid;
  logic [4:0]  opcode_in;
  logic [2:0]  funct_in;
  logic        nop_instr_in;
  logic [3:0]  exception_in;
  logic        exception_in_valid;
  logic [31:0] result_in;
  logic [31:0] addr_in;
  logic [4:0]  rd_addr_in;
  logic        stall_in;
  logic        flush_in;
  logic        stall_out;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        pipeline_out_valid;
  logic        wb_en;
  logic [31:0] wb_data;
  logic [4:0]  rd_addr_out;
  logic [3:0]  exception_out;
  logic        exception_out_valid;

  mem_access dut (
    .clk(clk), .reset(reset),
    .pipeline_in_valid(pipeline_in_valid),
    .opcode_in(opcode_in), .funct_in(funct_in),
    .nop_instr_in(nop_instr_in),
    .exception_in(exception_in),
    .exception_in_valid(exception_in_valid),
    .result_in(result_in), .addr_in(addr_in),
    .rd_addr_in(rd_addr_in),
    .stall_in(stall_in), .flush_in(flush_in),
    .stall_out(stall_out),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata),
    .pipeline_out_valid(pipeline_out_valid),
    .wb_en(wb_en), .wb_data(wb_data),
    .rd_addr_out(rd_addr_out),
    .exception_out(exception_out),
    .exception_out_valid(exception_out_valid)
  );

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 0;

  // Expected outputs for the current cycle.
  logic        e_valid, e_wben, e_excv, e_stall, e_req, e_we;
  logic [31:0] e_data, e_addr, e_wdata;
  logic [4:0]  e_rd;
  logic [3:0]  e_exc, e_be;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ctrl",
          {pipeline_out_valid, wb_en, exception_out_valid,
           stall_out, dmem_req},
          {e_valid, e_wben, e_excv, e_stall, e_req});
      if (e_valid)
        chk("wb", {wb_data, rd_addr_out, exception_out},
            {e_data, e_rd, e_exc});
      if (e_req) begin
        chk("dmem", {dmem_we, dmem_addr, dmem_be},
            {e_we, e_addr, e_be});
        if (e_we) chk("wdata", dmem_wdata, e_wdata);
      end
    end
  end

  function automatic int size_of(logic [2:0] f);
    if (f[1:0] == 2'b00) return 1;
    if (f[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit misal(logic [2:0] f, logic [31:0] a);
    return (a % size_of(f)) != 0;
  endfunction

  function automatic logic [3:0] be_of(logic [2:0] f, logic [31:0] a);
    int sz = size_of(f);
    if (sz == 4) return 4'hF;
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] wdata_of(logic [2:0] f, logic [31:0] d);
    int sz = size_of(f);
    logic [31:0] b = {24'b0, d[7:0]};
    logic [31:0] h = {16'b0, d[15:0]};
    if (sz == 1) return b * 32'h01010101;
    if (sz == 2) return h * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] ld_ext(logic [2:0] f, logic [1:0] lane,
                                         logic [31:0] w);
    logic [31:0] s = w >> (8 * lane);
    case (f)
      3'b000:  return 32'($signed(s[7:0]));
      3'b001:  return 32'($signed(s[15:0]));
      3'b100:  return 32'(s[7:0]);
      3'b101:  return 32'(s[15:0]);
      default: return w;
    endcase
  endfunction

  function automatic bit writes_reg(logic [4:0] op);
    return op inside {OP_ARITH, OP_IMM, OP_LUI, OP_AUIPC,
                      OP_JAL, OP_JALR, OP_LOAD};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    pipeline_in_valid  = 0;
    nop_instr_in       = 0;
    exception_in_valid = 0;
    stall_in           = 0;
    flush_in           = 0;
    dmem_ack           = 0;
    e_stall            = 0;
  endtask

  task automatic outs_clear();
    e_valid = 0;
    e_wben  = 0;
    e_excv  = 0;
  endtask

  task automatic set_out(bit w, bit xv, logic [3:0] x,
                         logic [31:0] d, logic [4:0] rd);
    e_valid = 1;
    e_wben  = w;
    e_excv  = xv;
    e_exc   = x;
    e_data  = d;
    e_rd    = rd;
  endtask

  task automatic drive(logic [4:0] op, logic [2:0] f, bit nop, bit xv,
                       logic [3:0] x, logic [31:0] res, logic [31:0] ad,
                       logic [4:0] rd);
    pipeline_in_valid  = 1;
    opcode_in          = op;
    funct_in           = f;
    nop_instr_in       = nop;
    exception_in_valid = xv;
    exception_in       = x;
    result_in          = res;
    addr_in            = ad;
    rd_addr_in         = rd;
  endtask

  // One-cycle instruction: non-memory, bubble, upstream fault or misaligned.
  task automatic simple(logic [4:0] op, logic [2:0] f, bit nop, bit xv,
                        logic [3:0] x, logic [31:0] res, logic [31:0] ad,
                        logic [4:0] rd, int pre_stall, bit flush_first);
    bit ld = op == OP_LOAD;
    bit mem = !nop && !xv && (ld || op == OP_STORE);
    logic [31:0] a = ld ? res : ad;
    drive(op, f, nop, xv, x, res, ad, rd);
    e_stall = 0;
    if (flush_first) begin
      flush_in = 1;
      stall_in = 1;
      tick();
      outs_clear();
      flush_in = 0;
    end
    repeat (pre_stall) begin
      stall_in = 1;
      tick();
    end
    stall_in = 0;
    tick();
    if (mem)
      set_out(0, 1, ld ? 4'd4 : 4'd6, a, rd);
    else
      set_out(!nop && !xv && rd != 0 && writes_reg(op),
              xv && !nop, (xv && !nop) ? x : 4'd0, res, rd);
    set_idle();
  endtask

  // Aligned load/store through the handshake; cycle k counts WAIT cycles.
  task automatic mem_op(logic [4:0] op, logic [2:0] f, logic [31:0] res,
                        logic [31:0] ad, logic [4:0] rd, logic [31:0] rdv,
                        int pre_stall, int delay, int flush_at,
                        bit stall_done, int resp_hold, bit resp_flush);
    bit ld = op == OP_LOAD;
    logic [31:0] a = ld ? res : ad;
    bit draining = 0;
    bit done = 0;
    bit ack, to, fl, st;
    bit r_w, r_xv;
    logic [3:0] r_x;
    logic [31:0] r_d;
    drive(op, f, 0, 0, 4'd0, res, ad, rd);
    e_stall = 1;
    repeat (pre_stall) begin
      stall_in = 1;
      tick();
    end
    stall_in = 0;
    tick();
    outs_clear();
    e_req   = 1;
    e_we    = !ld;
    e_addr  = {a[31:2], 2'b00};
    e_be    = be_of(f, a);
    e_wdata = wdata_of(f, res);
    for (int k = 0; k < 15 && !done; k++) begin
      ack = (k == delay);
      to  = !ack && (k == 14);
      fl  = (k == flush_at) && !draining;
      st  = (ack || to) ? stall_done : 1'($urandom_range(0, 1));
      dmem_ack   = ack;
      dmem_rdata = ack ? rdv : $urandom;
      flush_in   = fl;
      stall_in   = st;
      e_stall    = draining ? 1'b1 : !(ack || to);
      if (draining || fl) begin
        tick();
        if (ack || to) begin
          e_req = 0;
          done  = 1;
        end else begin
          draining = 1;
        end
      end else if (ack || to) begin
        r_w  = ack && ld && rd != 0;
        r_xv = !ack;
        r_x  = ack ? 4'd0 : (ld ? 4'd5 : 4'd7);
        r_d  = ack ? (ld ? ld_ext(f, a[1:0], rdv) : 32'd0) : a;
        tick();
        e_req = 0;
        if (!st) begin
          set_out(r_w, r_xv, r_x, r_d, rd);
        end else begin
          dmem_ack = 0;
          e_stall  = 1;
          repeat (resp_hold) tick();
          stall_in = 0;
          if (resp_flush) begin
            flush_in = 1;
            stall_in = 1'($urandom_range(0, 1));
            tick();
          end else begin
            tick();
            set_out(r_w, r_xv, r_x, r_d, rd);
          end
        end
        done = 1;
      end else begin
        tick();
      end
    end
    set_idle();
  endtask

  task automatic issue(logic [4:0] op, logic [2:0] f, bit nop, bit xv,
                       logic [3:0] x, logic [31:0] res, logic [31:0] ad,
                       logic [4:0] rd, logic [31:0] rdv, int pre_stall,
                       bit flush_first, int delay, int flush_at,
                       bit stall_done, int resp_hold, bit resp_flush);
    bit ld = op == OP_LOAD;
    bit mem = !nop && !xv && (ld || op == OP_STORE);
    if (mem && !misal(f, ld ? res : ad))
      mem_op(op, f, res, ad, rd, rdv, pre_stall, delay, flush_at,
             stall_done, resp_hold, resp_flush);
    else
      simple(op, f, nop, xv, x, res, ad, rd, pre_stall, flush_first);
  endtask

  logic [4:0] alu_ops [8];
  logic [2:0] ld_f [5];

  initial begin
    alu_ops = '{OP_ARITH, OP_IMM, OP_LUI, OP_AUIPC,
                OP_JAL, OP_JALR, 5'b11000, 5'b00011};
    ld_f = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    reset = 1;
    opcode_in = 0; funct_in = 0; exception_in = 0;
    result_in = 0; addr_in = 0; rd_addr_in = 0; dmem_rdata = 0;
    set_idle();
    outs_clear();
    e_req = 0; e_we = 0; e_data = 0; e_addr = 0; e_wdata = 0;
    e_rd = 0; e_exc = 0; e_be = 0;

    // Model pins.
    chk("pin_lb",  ld_ext(3'b000, 2'd3, 32'h80FF0000), 32'hFFFFFF80);
    chk("pin_lbu", ld_ext(3'b100, 2'd3, 32'h80FF0000), 32'h00000080);
    chk("pin_lhu", ld_ext(3'b101, 2'd2, 32'h80FF0000), 32'h000080FF);
    chk("pin_be",  be_of(3'b001, 32'h102), 4'b1100);
    chk("pin_wd",  wdata_of(3'b001, 32'h0000ABCD), 32'hABCDABCD);
    chk("pin_mis", misal(3'b010, 32'h102), 1'b1);

    tick();
    chk_en = 1;
    tick();
    chk("reset", {pipeline_out_valid, wb_en, exception_out_valid,
                  stall_out, dmem_req, dmem_we, dmem_be, wb_data,
                  exception_out}, '0);
    reset = 0;
    tick();

    // LW with ack after two WAIT cycles.
    mem_op(OP_LOAD, 3'b010, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF,
           0, 2, -1, 0, 0, 0);
    chk("t1_data", {wb_en, rd_addr_out, wb_data}, {1'b1, 5'd5, 32'hDEADBEEF});
    mem_op(OP_LOAD, 3'b000, 32'h103, 32'h0, 5'd7, 32'h80FF0000,
           0, 0, -1, 0, 0, 0);
    chk("t2_lb", wb_data, 32'hFFFFFF80);
    mem_op(OP_LOAD, 3'b100, 32'h103, 32'h0, 5'd7, 32'h80FF0000,
           0, 1, -1, 0, 0, 0);
    chk("t2_lbu", wb_data, 32'h00000080);
    mem_op(OP_LOAD, 3'b101, 32'h102, 32'h0, 5'd7, 32'h80FF0000,
           0, 1, -1, 0, 0, 0);
    chk("t2_lhu", wb_data, 32'h000080FF);
    mem_op(OP_STORE, 3'b001, 32'h0000ABCD, 32'h102, 5'd9, 32'h0,
           0, 1, -1, 0, 0, 0);
    chk("t3_st_wben", wb_en, 1'b0);
    simple(OP_LOAD, 3'b010, 0, 0, 4'd0, 32'h102, 32'h0, 5'd3, 0, 0);
    chk("t4_mis", {exception_out_valid, exception_out, dmem_req},
        {1'b1, 4'd4, 1'b0});
    simple(OP_ARITH, 3'b000, 0, 0, 4'd0, 32'h55, 32'h0, 5'd0, 0, 0);
    chk("t4_rd0", {pipeline_out_valid, wb_en}, 2'b10);
    mem_op(OP_LOAD, 3'b010, 32'h200, 32'h0, 5'd4, 32'h12345678,
           0, 3, 0, 0, 0, 0);
    mem_op(OP_LOAD, 3'b010, 32'h300, 32'h0, 5'd6, 32'h0,
           0, 99, -1, 0, 0, 0);
    chk("t6_to", {exception_out_valid, exception_out}, {1'b1, 4'd5});
    mem_op(OP_LOAD, 3'b010, 32'h304, 32'h0, 5'd8, 32'hCAFEF00D,
           0, 1, -1, 1, 2, 0);
    chk("t6_resp", wb_data, 32'hCAFEF00D);
    mem_op(OP_STORE, 3'b000, 32'h77, 32'h401, 5'd1, 32'h0,
           1, 99, -1, 1, 1, 0);
    mem_op(OP_LOAD, 3'b001, 32'h402, 32'h0, 5'd2, 32'h11112222,
           0, 2, -1, 1, 1, 1);
    simple(OP_LUI, 3'b000, 0, 0, 4'd0, 32'h9000, 32'h0, 5'd3, 1, 1);

    // Reset while an access is outstanding.
    drive(OP_LOAD, 3'b010, 0, 0, 4'd0, 32'h500, 32'h0, 5'd2);
    e_stall = 1;
    tick();
    outs_clear();
    e_req = 1; e_we = 0; e_addr = 32'h500; e_be = 4'hF;
    tick();
    reset = 1;
    set_idle();
    e_stall = 1;
    tick();
    e_req = 0;
    e_stall = 0;
    reset = 0;
    tick();

    for (int i = 0; i < 250; i++) begin
      logic [4:0] op;
      logic [2:0] f;
      logic [31:0] res, ad;
      int dly, fat;
      if ($urandom_range(0, 9) < 4) begin
        op = $urandom_range(0, 1) ? OP_LOAD : OP_STORE;
        f = (op == OP_LOAD) ? ld_f[$urandom_range(0, 4)]
                            : 3'($urandom_range(0, 2));
      end else begin
        op = alu_ops[$urandom_range(0, 7)];
        f = 3'($urandom);
      end
      res = $urandom;
      ad = $urandom;
      if ($urandom_range(0, 9) < 6) begin
        res[1:0] = 2'b00;
        ad[1:0] = 2'b00;
      end
      dly = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 6);
      fat = ($urandom_range(0, 6) == 0) ? $urandom_range(0, 7) : -1;
      issue(op, f, $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0, 4'($urandom),
            res, ad, 5'($urandom), $urandom,
            ($urandom_range(0, 4) == 0) ? 1 : 0,
            $urandom_range(0, 9) == 0, dly, fat,
            $urandom_range(0, 2) == 0, $urandom_range(0, 2),
            $urandom_range(0, 6) == 0);
      if ($urandom_range(0, 4) == 0) begin
        tick();
        outs_clear();
      end
    end
    tick();
    outs_clear();
    tick();
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
